// File: rtl/spike_event_queue.sv
// spike_event_queue
//   Serialises each timestep's parallel spike vector into a stream of
//   spiking-neuron addresses, buffered in a show-ahead FIFO for the host.
//
//   Ports
//     clock            in   rising-edge clock
//     reset_n          in   asynchronous active-low reset
//     spike_valid      in   one-cycle strobe qualifying spike_vec
//     spike_vec        in   [N_NEURONS] bit k set -> neuron k spiked
//     snn_ren          in   pop the head entry at this edge (ignored when empty)
//     snn_event        out  FIFO non-empty, head entry valid
//     neuron_addr_out  out  [ADDR_W] head entry address, 0 when empty
//     fifo_count       out  [$clog2(DEPTH+1)] occupancy 0..DEPTH
//     busy             out  spikes pending or FIFO non-empty
//     overrun          out  sticky: a spike merged into an already-pending bit
module spike_event_queue #(
   parameter int unsigned N_NEURONS = 16,
   parameter int unsigned ADDR_W    = $clog2(N_NEURONS),
   parameter int unsigned DEPTH     = 8
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic                       spike_valid,
   input  logic [N_NEURONS-1:0]       spike_vec,
   input  logic                       snn_ren,
   output logic                       snn_event,
   output logic [ADDR_W-1:0]          neuron_addr_out,
   output logic [$clog2(DEPTH+1)-1:0] fifo_count,
   output logic                       busy,
   output logic                       overrun
);

   localparam int unsigned CNT_W = $clog2(DEPTH+1);
   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [N_NEURONS-1:0] pending;
   logic [N_NEURONS-1:0] grant;
   logic [N_NEURONS-1:0] clr;
   logic [ADDR_W-1:0]    grant_addr;
   logic                 found;
   logic [ADDR_W-1:0]    mem [DEPTH];
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic                 full;
   logic                 pop;
   logic                 push;
   logic [N_NEURONS-1:0] new_spikes;

   // Lowest-index pending bit wins the grant.
   always_comb begin
      grant      = '0;
      grant_addr = '0;
      found      = 1'b0;
      for (int unsigned k = 0; k < N_NEURONS; k++) begin
         if (pending[k] && !found) begin
            grant[k]   = 1'b1;
            grant_addr = ADDR_W'(k);
            found      = 1'b1;
         end
      end
   end

   always_comb begin
      full       = (fifo_count == CNT_W'(DEPTH));
      pop        = snn_ren & snn_event;
      // A pop at full frees the slot the push needs in the same cycle.
      push       = (|pending) & (~full | pop);
      clr        = push ? grant : '0;
      new_spikes = spike_valid ? spike_vec : '0;
   end

   // A same-cycle spike on the granted bit re-arms it rather than being lost.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pending <= '0;
         overrun <= 1'b0;
      end else begin
         pending <= (pending & ~clr) | new_spikes;
         if (|(new_spikes & pending & ~clr))
            overrun <= 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (push)
         mem[wr_ptr] <= grant_addr;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CNT_W'(1);
            2'b01:   fifo_count <= fifo_count - CNT_W'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   always_comb begin
      snn_event       = (fifo_count != '0);
      neuron_addr_out = snn_event ? mem[rd_ptr] : '0;
      busy            = (|pending) | snn_event;
   end

endmodule

// File: tb/tb_spike_event_queue.sv
// tb_spike_event_queue
//   Self-checking bench for spike_event_queue: a fixed vector table for
//   the ordering case, hand-written multi-cycle sequences, and randomized
//   traffic checked against a queue-based reference model.
module tb_spike_event_queue;

   localparam int N  = 16;
   localparam int AW = 4;
   localparam int D  = 8;
   localparam int CW = 4;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          spike_valid = 1'b0;
   logic [N-1:0]  spike_vec = '0;
   logic          snn_ren = 1'b0;
   logic          snn_event;
   logic [AW-1:0] neuron_addr_out;
   logic [CW-1:0] fifo_count;
   logic          busy;
   logic          overrun;

   spike_event_queue #(.N_NEURONS(N), .ADDR_W(AW), .DEPTH(D)) dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .spike_valid     (spike_valid),
      .spike_vec       (spike_vec),
      .snn_ren         (snn_ren),
      .snn_event       (snn_event),
      .neuron_addr_out (neuron_addr_out),
      .fifo_count      (fifo_count),
      .busy            (busy),
      .overrun         (overrun)
   );

   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;

   // Reference model: pending neuron set, queue of addresses, sticky flag.
   logic [N-1:0] m_p;
   int           m_q[$];
   bit           m_ovr;

   typedef struct {
      bit           v;
      logic [N-1:0] vec;
      bit           ren;
      bit           e_ev;
      int           e_addr;
      int           e_cnt;
      bit           e_busy;
   } vec_t;

   vec_t tbl[6];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_p   = '0;
      m_q.delete();
      m_ovr = 1'b0;
   endtask

   task automatic model_step(input bit v, input logic [N-1:0] vec, input bit ren);
      int           sz;
      bit           pop;
      int           tmp;
      logic [N-1:0] clr;
      sz  = m_q.size();
      pop = ren && (sz > 0);
      clr = '0;
      if (pop) tmp = m_q.pop_front();
      if (m_p != '0 && (sz < D || pop)) begin
         for (int k = 0; k < N; k++) begin
            if (m_p[k]) begin
               m_q.push_back(k);
               clr[k] = 1'b1;
               break;
            end
         end
      end
      if (v && ((vec & m_p & ~clr) != '0)) m_ovr = 1'b1;
      m_p = (m_p & ~clr) | (v ? vec : '0);
   endtask

   task automatic check_outputs(input string tag);
      int sz;
      sz = m_q.size();
      chk({tag, ".event"}, int'(snn_event), int'(sz > 0));
      chk({tag, ".addr"}, int'(neuron_addr_out), (sz > 0) ? m_q[0] : 0);
      chk({tag, ".count"}, int'(fifo_count), sz);
      chk({tag, ".busy"}, int'(busy), int'((m_p != '0) || (sz > 0)));
      chk({tag, ".overrun"}, int'(overrun), int'(m_ovr));
   endtask

   task automatic step(input string tag, input bit v, input logic [N-1:0] vec, input bit ren);
      spike_valid = v;
      spike_vec   = vec;
      snn_ren     = ren;
      @(posedge clock);
      #1;
      model_step(v, vec, ren);
      check_outputs(tag);
      spike_valid = 1'b0;
      spike_vec   = '0;
      snn_ren     = 1'b0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      model_reset();
      check_outputs("reset");
      chk("reset.event_const", int'(snn_event), 0);
      chk("reset.count_const", int'(fifo_count), 0);
      reset_n = 1'b1;
   endtask

   initial begin
      model_reset();

      // 1: reset
      do_reset();

      // 2: ordering, table-driven
      tbl[0] = '{1'b1, 16'h8025, 1'b0, 1'b0, 0,  0, 1'b1};
      tbl[1] = '{1'b0, 16'h0000, 1'b0, 1'b1, 0,  1, 1'b1};
      tbl[2] = '{1'b0, 16'h0000, 1'b1, 1'b1, 2,  1, 1'b1};
      tbl[3] = '{1'b0, 16'h0000, 1'b1, 1'b1, 5,  1, 1'b1};
      tbl[4] = '{1'b0, 16'h0000, 1'b1, 1'b1, 15, 1, 1'b1};
      tbl[5] = '{1'b0, 16'h0000, 1'b1, 1'b0, 0,  0, 1'b0};
      for (int i = 0; i < 6; i++) begin
         step("order", tbl[i].v, tbl[i].vec, tbl[i].ren);
         chk($sformatf("order[%0d].event", i), int'(snn_event), int'(tbl[i].e_ev));
         chk($sformatf("order[%0d].addr", i), int'(neuron_addr_out), tbl[i].e_addr);
         chk($sformatf("order[%0d].count", i), int'(fifo_count), tbl[i].e_cnt);
         chk($sformatf("order[%0d].busy", i), int'(busy), int'(tbl[i].e_busy));
      end

      // 3: full and stall
      step("full", 1'b1, 16'hFFFF, 1'b0);
      repeat (8) step("full", 1'b0, '0, 1'b0);
      chk("full.count8", int'(fifo_count), 8);
      chk("full.pending", int'(dut.pending), int'(16'hFF00));
      step("stall", 1'b0, '0, 1'b0);
      chk("stall.count8", int'(fifo_count), 8);
      chk("stall.pending", int'(dut.pending), int'(16'hFF00));
      for (int a = 0; a < 16; a++) begin
         chk($sformatf("full.drain%0d", a), int'(neuron_addr_out), a);
         step("drain", 1'b0, '0, 1'b1);
      end
      chk("full.empty", int'(snn_event), 0);

      // 4: overrun / merge
      step("merge", 1'b1, 16'h0003, 1'b0);
      step("merge", 1'b1, 16'h0006, 1'b0);
      chk("merge.overrun", int'(overrun), 1);
      for (int a = 0; a < 3; a++) begin
         chk($sformatf("merge.out%0d", a), int'(neuron_addr_out), a);
         step("merge", 1'b0, '0, 1'b1);
      end
      chk("merge.empty", int'(snn_event), 0);
      chk("merge.busy", int'(busy), 0);

      // 5: empty pop and pointer wrap
      step("epop", 1'b0, '0, 1'b1);
      chk("epop.count", int'(fifo_count), 0);
      for (int r = 0; r < 3; r++) begin
         step("wrap", 1'b1, 16'h0F00, 1'b0);
         step("wrap", 1'b0, '0, 1'b0);
         for (int a = 8; a < 12; a++) begin
            chk($sformatf("wrap%0d.out%0d", r, a), int'(neuron_addr_out), a);
            step("wrap", 1'b0, '0, 1'b1);
         end
         chk($sformatf("wrap%0d.empty", r), int'(snn_event), 0);
      end

      // 6: asynchronous reset mid-operation
      step("mid", 1'b1, 16'hFFFF, 1'b0);
      repeat (3) step("mid", 1'b0, '0, 1'b0);
      step("mid", 1'b0, '0, 1'b1);
      step("mid", 1'b0, '0, 1'b1);
      #2 reset_n = 1'b0;
      #1;
      chk("amid.event", int'(snn_event), 0);
      chk("amid.count", int'(fifo_count), 0);
      chk("amid.busy", int'(busy), 0);
      chk("amid.overrun", int'(overrun), 0);
      chk("amid.addr", int'(neuron_addr_out), 0);
      model_reset();
      #1 reset_n = 1'b1;
      step("post", 1'b1, 16'h0010, 1'b0);
      step("post", 1'b0, '0, 1'b0);
      chk("post.addr", int'(neuron_addr_out), 4);
      step("post", 1'b0, '0, 1'b1);
      chk("post.event", int'(snn_event), 0);
      chk("post.busy", int'(busy), 0);

      // Randomized traffic against the model
      do_reset();
      for (int i = 0; i < 600; i++) begin
         bit           v;
         logic [N-1:0] vec;
         bit           ren;
         v   = ($urandom_range(0, 3) == 0);
         vec = N'($urandom);
         if ($urandom_range(0, 1) == 0) vec = vec & N'($urandom);
         ren = (i % 100 < 40) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 1) == 1);
         step("rand", v, vec, ren);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
